// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer driving one external combinational full adder.
// Latency: operands accepted at edge T, out_valid rises after edge T+WIDTH; WIDTH+2 cycles per op.
// Backpressure: result held in DONE until out_ready; in_ready low in RUN and DONE (one bubble).
// Optional macro SERIAL_ADD_SUB_EN adds a 'sub' port for two's-complement a-b.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_carry
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // Partial sum: holds the upper WIDTH-1 bits collected so far; the final
    // bit from the FA is appended on the last RUN edge to form the result.
    logic [WIDTH-2:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic [WIDTH-1:0] sum_shift;
    logic             last_bit;

    // Operand conditioning at accept time: subtract inverts b and forces carry-in.
`ifdef SERIAL_ADD_SUB_EN
    always_comb begin
        b_load = sub ? ~b : b;
        c_load = sub ? 1'b1 : cin;
    end
`else
    always_comb begin
        b_load = b;
        c_load = cin;
    end
`endif

    assign sum_shift = {fa_sum, sum_sh_q};
    assign last_bit  = (cnt_q == CW'(WIDTH - 1));

    // Next-state, datapath next values and handshake/FA outputs.
    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        sum_sh_d  = sum_sh_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        fa_a      = 1'b0;
        fa_b      = 1'b0;
        fa_cin    = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b_load;
                    carry_d = c_load;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                fa_a     = a_sh_q[0];
                fa_b     = b_sh_q[0];
                fa_cin   = carry_q;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = sum_shift[WIDTH-1:1];
                carry_d  = fa_carry;
                if (last_bit) begin
                    // Counter holds on the last bit so it never wraps mid-op.
                    sum_d   = sum_shift;
                    cout_d  = fa_carry;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial sequencer that computes a WIDTH-bit add by driving one external gate-level full adder (FA_GL) for WIDTH consecutive cycles.
- Operands are accepted with a valid/ready handshake, and the result is returned the same way.
- Sits between an operand source and a result sink; the full adder is instanced beside it and wired through the fa_* ports.
- Trades area (one FA) for latency (WIDTH cycles per operation).

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  reset, asynchronous assert, active-low.
in_valid  input  1  operand source has a, b, cin valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in for the whole add.
out_valid  output  1  sum and cout valid.
out_ready  input  1  result sink accepts the result.
sum  output  WIDTH  result.
cout  output  1  carry-out of the MSB.
fa_a  output  1  to FA_GL ip1.
fa_b  output  1  to FA_GL ip2.
fa_cin  output  1  to FA_GL ip3.
fa_sum  input  1  from FA_GL sum.
fa_carry  input  1  from FA_GL carry.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE; shift registers, carry register and bit counter clear to 0.
  - Outputs: in_ready=1, out_valid=0, sum=0, cout=0, fa_a=fa_b=fa_cin=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1; fa_* outputs driven 0.
  - On in_valid=1 at a clock edge: a_sh<=a, b_sh<=b, carry_q<=cin, cnt<=0, and the FSM moves to RUN.
- RUN:
  - in_ready=0; fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry_q (combinational from registers).
  - Each edge: a_sh and b_sh shift right by 1; sum_sh shifts right with fa_sum entering at bit WIDTH-1; carry_q<=fa_carry; cnt<=cnt+1.
  - When cnt==WIDTH-1 at an edge, that edge is the last bit and the FSM moves to DONE.
  - The counter is $clog2(WIDTH) bits wide and does not wrap within an operation.
- DONE:
  - out_valid=1; sum=sum_sh; cout=carry_q. Both are held stable while out_ready=0.
  - On out_ready=1 at an edge, the FSM moves to IDLE. sum and cout keep their last value until the next DONE.
  - in_ready=0 in DONE, so there is one bubble cycle between result handoff and the next operand accept.
- Latency: operands accepted at edge T; out_valid rises after edge T+WIDTH. Throughput is one op per WIDTH+2 cycles with out_ready held high.
- in_valid is ignored while in RUN or DONE; a, b and cin may change freely after acceptance.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately; no result is produced.
- fa_sum and fa_carry are sampled only in RUN.
- The external FA is purely combinational, so the single-cycle path is reg -> FA -> reg.

Optional Feature:
Macro: SERIAL_ADD_SUB_EN
- Defined:
  - Adds input port sub (1 bit), sampled with in_valid.
  - If sub=1: b_sh<=~b, carry_q<=1 and cin is ignored, so the block computes a-b in two's complement; cout=1 means no borrow.
  - If sub=0: behaviour is identical to the add case.
- Not defined: no sub port; add only.

Test Plan:
- Test 1, basic add: WIDTH=8, a=0x5A, b=0x33, cin=0 -> out_valid after 8 cycles, sum=0x8D, cout=0.
- Test 2, full carry ripple: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Test 3, backpressure: a=0x12, b=0x34, cin=0, out_ready=0 for 5 cycles after out_valid -> sum=0x46 held stable, out_valid stays 1, in_ready=0; set out_ready=1 -> IDLE next cycle, in_ready=1.
- Test 4, reset mid-operation: start a=0xAA, b=0x55, assert rst_n=0 at cycle 3 of RUN -> out_valid=0, sum=0, in_ready=1 immediately. Then a=0x01, b=0x02 -> sum=0x03, cout=0.
- Test 5, back-to-back ops: in_valid and out_ready held 1 with a=0x10,b=0x20 then a=0x7F,b=0x01 -> results 0x30 then 0x80, ops accepted 10 cycles apart, in_valid ignored during RUN.
- Test 6, subtract (SERIAL_ADD_SUB_EN): a=0x10, b=0x01, sub=1 -> sum=0x0F, cout=1. Then a=0x01, b=0x02, sub=1 -> sum=0xFF, cout=0.
